// File: rtl/cpu_step_controller.sv
// Processor clock-enable generator: halt, programmable-rate run, debounced single-step
// and N-cycle burst modes, plus an executed-cycle counter and heartbeat LED.
module cpu_step_controller #(
    parameter int CNT_W           = 28,
    parameter int DEFAULT_DIV     = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] div_value,
    input  logic             div_load,
    input  logic             step_btn,
    input  logic [15:0]      burst_len,
    input  logic             burst_start,
    output logic             cpu_ce,
    output logic             busy,
    output logic             burst_done,
    output logic [31:0]      cycle_count,
    output logic             tick_led
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    typedef enum logic [2:0] {ST_HALT, ST_RUN, ST_STEP, ST_BURST, ST_DONE} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  div_reg, div_next;
    logic [CNT_W-1:0]  prescaler_reg, prescaler_next;
    logic [15:0]       remaining_reg, remaining_next;
    logic              cpu_ce_reg, cpu_ce_next;
    logic              burst_done_reg, burst_done_next;
    logic [31:0]       cycle_count_reg;
    logic              tick_led_reg;
    logic              tick;

    logic [1:0]        sync_reg;
    logic [DB_W-1:0]   db_cnt_reg;
    logic              db_level_reg;
    logic              db_prev_reg;
    logic              step_pulse;

    // Button path: two-flop synchroniser, then the level only flips after a full run of
    // consecutive samples that disagree with it.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync_reg     <= 2'b00;
            db_cnt_reg   <= '0;
            db_level_reg <= 1'b0;
            db_prev_reg  <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], step_btn};
            db_prev_reg <= db_level_reg;
            if (sync_reg[1] != db_level_reg) begin
                if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_level_reg <= sync_reg[1];
                    db_cnt_reg   <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + DB_W'(1);
                end
            end else begin
                db_cnt_reg <= '0;
            end
        end
    end

    assign step_pulse = db_level_reg & ~db_prev_reg;
    assign tick       = (prescaler_reg == div_reg - CNT_W'(1));

    always_comb begin
        state_next      = state_reg;
        remaining_next  = remaining_reg;
        cpu_ce_next     = 1'b0;
        burst_done_next = 1'b0;
        div_next        = div_reg;
        prescaler_next  = '0;

        case (state_reg)
            ST_HALT: begin
                if (mode == MODE_RUN) begin
                    state_next = ST_RUN;
                end else if (mode == MODE_STEP) begin
                    state_next = ST_STEP;
                end else if (mode == MODE_BURST && burst_start && burst_len != 16'd0) begin
                    state_next     = ST_BURST;
                    remaining_next = burst_len;
                end
            end
            ST_RUN: begin
                // A mode change beats a coincident tick: the abort issues no enable.
                if (mode != MODE_RUN) begin
                    state_next = ST_HALT;
                end else if (tick) begin
                    cpu_ce_next = 1'b1;
                end
            end
            ST_STEP: begin
                if (mode != MODE_STEP) begin
                    state_next = ST_HALT;
                end else if (step_pulse) begin
                    cpu_ce_next = 1'b1;
                end
            end
            ST_BURST: begin
                if (mode != MODE_BURST) begin
                    state_next     = ST_HALT;
                    remaining_next = 16'd0;
                end else if (tick) begin
                    cpu_ce_next    = 1'b1;
                    remaining_next = remaining_reg - 16'd1;
                    if (remaining_reg == 16'd1) begin
                        state_next      = ST_DONE;
                        burst_done_next = 1'b1;
                    end
                end
            end
            ST_DONE: state_next = ST_HALT;
            default: state_next = ST_HALT;
        endcase

        // Prescaler only runs while staying in a timed state; leaving clears it.
        if ((state_reg == ST_RUN || state_reg == ST_BURST) &&
            (state_next == ST_RUN || state_next == ST_BURST)) begin
            prescaler_next = tick ? '0 : prescaler_reg + CNT_W'(1);
        end

        if (div_load) begin
            div_next       = (div_value < CNT_W'(2)) ? CNT_W'(2) : div_value;
            prescaler_next = '0;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_reg       <= ST_HALT;
            div_reg         <= CNT_W'(DEFAULT_DIV);
            prescaler_reg   <= '0;
            remaining_reg   <= 16'd0;
            cpu_ce_reg      <= 1'b0;
            burst_done_reg  <= 1'b0;
            cycle_count_reg <= 32'd0;
            tick_led_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            div_reg        <= div_next;
            prescaler_reg  <= prescaler_next;
            remaining_reg  <= remaining_next;
            cpu_ce_reg     <= cpu_ce_next;
            burst_done_reg <= burst_done_next;
            if (cpu_ce_next) begin
                cycle_count_reg <= cycle_count_reg + 32'd1;
                tick_led_reg    <= ~tick_led_reg;
            end
        end
    end

    assign cpu_ce      = cpu_ce_reg;
    assign burst_done  = burst_done_reg;
    assign cycle_count = cycle_count_reg;
    assign tick_led    = tick_led_reg;
    assign busy        = (state_reg == ST_RUN) || (state_reg == ST_BURST);

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller with DEFAULT_DIV=4 and DEBOUNCE_CYCLES=4.
module tb_cpu_step_controller;

    localparam int CNT_W = 28;

    logic             clock_in    = 1'b0;
    logic             reset       = 1'b1;
    logic [1:0]       mode        = 2'b00;
    logic [CNT_W-1:0] div_value   = '0;
    logic             div_load    = 1'b0;
    logic             step_btn    = 1'b0;
    logic [15:0]      burst_len   = 16'd0;
    logic             burst_start = 1'b0;
    logic             cpu_ce;
    logic             busy;
    logic             burst_done;
    logic [31:0]      cycle_count;
    logic             tick_led;

    int checks   = 0;
    int errors   = 0;
    int ce_cnt   = 0;
    int done_cnt = 0;
    int base     = 0;

    cpu_step_controller #(
        .CNT_W          (CNT_W),
        .DEFAULT_DIV    (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .mode       (mode),
        .div_value  (div_value),
        .div_load   (div_load),
        .step_btn   (step_btn),
        .burst_len  (burst_len),
        .burst_start(burst_start),
        .cpu_ce     (cpu_ce),
        .busy       (busy),
        .burst_done (burst_done),
        .cycle_count(cycle_count),
        .tick_led   (tick_led)
    );

    always #5 clock_in = ~clock_in;

    always @(negedge clock_in) begin
        if (cpu_ce === 1'b1) ce_cnt++;
        if (burst_done === 1'b1) done_cnt++;
    end

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_ce", 32'(cpu_ce), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(burst_done), 32'd0);
        check("rst_count", cycle_count, 32'd0);
        check("rst_led", 32'(tick_led), 32'd0);
        check("rst_div", 32'(dut.div_reg), 32'd4);
        reset = 1'b0;

        // 1: free run at divisor 4
        mode = 2'b01;
        for (int k = 0; k < 40; k++) begin
            step();
            check("t1_ce", 32'(cpu_ce), (k >= 4 && k % 4 == 0) ? 32'd1 : 32'd0);
            if (k == 0) check("t1_busy", 32'(busy), 32'd1);
        end
        check("t1_count", cycle_count, 32'd9);
        check("t1_led", 32'(tick_led), 32'd1);
        mode = 2'b00;                       // coincides with a tick: abort wins
        step();
        check("t1_abort_ce", 32'(cpu_ce), 32'd0);
        check("t1_abort_busy", 32'(busy), 32'd0);
        check("t1_abort_count", cycle_count, 32'd9);

        // 2: divisor 1 clamps to 2
        div_value = 28'd1;
        div_load  = 1'b1;
        step();
        div_load = 1'b0;
        check("t2_div", 32'(dut.div_reg), 32'd2);
        mode = 2'b01;
        for (int k = 0; k < 12; k++) begin
            step();
            check("t2_ce", 32'(cpu_ce), (k >= 2 && k % 2 == 0) ? 32'd1 : 32'd0);
        end
        mode = 2'b00;
        step();
        check("t2_count", cycle_count, 32'd14);
        check("t2_led", 32'(tick_led), 32'd0);
        div_value = 28'd4;
        div_load  = 1'b1;
        step();
        div_load = 1'b0;

        // 3: single step with bounce, re-press, glitch, and pulse outside STEP
        mode = 2'b10;
        step();
        base = ce_cnt;
        step_btn = 1'b1; step();
        step_btn = 1'b0; step();
        step_btn = 1'b1;
        repeat (20) step();
        check("t3_bounce_once", 32'(ce_cnt - base), 32'd1);
        step_btn = 1'b0;
        repeat (8) step();
        check("t3_release", 32'(ce_cnt - base), 32'd1);
        step_btn = 1'b1;
        repeat (6) step();
        step_btn = 1'b0;
        repeat (8) step();
        check("t3_second", 32'(ce_cnt - base), 32'd2);
        step_btn = 1'b1;
        repeat (3) step();
        step_btn = 1'b0;
        repeat (8) step();
        check("t3_glitch", 32'(ce_cnt - base), 32'd2);
        mode = 2'b00;
        step();
        step_btn = 1'b1;
        repeat (10) step();
        step_btn = 1'b0;
        repeat (8) step();
        check("t3_halt_discard", 32'(ce_cnt - base), 32'd2);
        check("t3_count", cycle_count, 32'd16);

        // 4: 3-cycle burst, then a zero-length request
        mode        = 2'b11;
        burst_len   = 16'd3;
        burst_start = 1'b1;
        step();
        burst_start = 1'b0;
        check("t4_busy0", 32'(busy), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            step();
            check("t4_ce", 32'(cpu_ce), (k % 4 == 0) ? 32'd1 : 32'd0);
            check("t4_done", 32'(burst_done), (k == 12) ? 32'd1 : 32'd0);
            check("t4_busy", 32'(busy), (k < 12) ? 32'd1 : 32'd0);
        end
        step();
        check("t4_done_after", 32'(burst_done), 32'd0);
        check("t4_done_cnt", 32'(done_cnt), 32'd1);
        check("t4_count", cycle_count, 32'd19);
        base        = ce_cnt;
        burst_len   = 16'd0;
        burst_start = 1'b1;
        step();
        burst_start = 1'b0;
        check("t4_zero_busy", 32'(busy), 32'd0);
        repeat (8) step();
        check("t4_zero_ce", 32'(ce_cnt - base), 32'd0);

        // 5: burst aborted after two enables
        burst_len   = 16'd10;
        burst_start = 1'b1;
        step();
        burst_start = 1'b0;
        repeat (8) step();
        check("t5_ce2", 32'(cpu_ce), 32'd1);
        mode = 2'b00;
        step();
        check("t5_busy", 32'(busy), 32'd0);
        repeat (10) step();
        check("t5_count", cycle_count, 32'd21);
        check("t5_no_done", 32'(done_cnt), 32'd1);

        // 6: counter wrap, then reset mid-run
        div_value = 28'd3;
        div_load  = 1'b1;
        step();
        div_load = 1'b0;
        force dut.cycle_count_reg = 32'hFFFF_FFFF;
        step();
        release dut.cycle_count_reg;
        check("t6_forced", cycle_count, 32'hFFFF_FFFF);
        mode = 2'b01;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t6_ce", 32'(cpu_ce), (k == 3) ? 32'd1 : 32'd0);
        end
        check("t6_wrap", cycle_count, 32'd0);
        check("t6_led", 32'(tick_led), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        check("t6_rst_ce", 32'(cpu_ce), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(burst_done), 32'd0);
        check("t6_rst_count", cycle_count, 32'd0);
        check("t6_rst_led", 32'(tick_led), 32'd0);
        check("t6_rst_div", 32'(dut.div_reg), 32'd4);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t6_post_ce", 32'(cpu_ce), (k == 4) ? 32'd1 : 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
